// File: rtl/lif_pkg.sv
// lif_pkg: shared constants and ISI state type for the LIF neuron readback path.
package lif_pkg;
    localparam int LIF_WINDOW_LOG2 = 8;
    localparam int LIF_CNT_W = 8;
    localparam int LIF_ISI_W = 8;
    typedef enum logic {ISI_WAIT, ISI_RUN} isi_state_t;
endpackage

// File: rtl/spike_edge_det.sv
// spike_edge_det: rising-edge detector on a spike line; a held-high spike yields one evt.
module spike_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic spike,
    output logic evt
);
    logic spk_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) spk_q <= 1'b0;
        else spk_q <= spike;
    end
    assign evt = spike & ~spk_q;
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: recovers a value from a spike train as a windowed edge rate
// and the inter-spike interval between consecutive edges.
module spike_rate_decoder
    import lif_pkg::*;
#(
    parameter int WINDOW_LOG2 = LIF_WINDOW_LOG2,
    parameter int CNT_W = LIF_CNT_W,
    parameter int ISI_W = LIF_ISI_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic             rate_sat,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid
);
    logic evt, term, sat_hit;
    logic [WINDOW_LOG2-1:0] win;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic sticky;
    logic [ISI_W-1:0] isi_cnt;
    isi_state_t state, state_nxt;

    spike_edge_det u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .spike(spike),
        .evt  (evt)
    );

    assign term    = ena & (&win);
    assign sat_hit = evt & (&cnt);
    assign cnt_inc = cnt + CNT_W'(evt & ~(&cnt));

    // An event on the terminal cycle is folded into the closing window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win        <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            rate       <= '0;
            rate_sat   <= 1'b0;
            rate_valid <= 1'b0;
        end else if (!ena) begin
            win        <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            rate_valid <= 1'b0;
        end else begin
            win        <= win + 1'b1;
            rate_valid <= term;
            rate       <= term ? cnt_inc : rate;
            rate_sat   <= term ? (sticky | sat_hit) : rate_sat;
            cnt        <= term ? '0 : cnt_inc;
            sticky     <= term ? 1'b0 : (sticky | sat_hit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ISI_WAIT;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = !ena ? ISI_WAIT : (evt ? ISI_RUN : state);
    end

    // The first edge after ISI_WAIT only arms the interval counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_cnt   <= '0;
            isi       <= '0;
            isi_valid <= 1'b0;
        end else if (!ena) begin
            isi_cnt   <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= evt & (state == ISI_RUN);
            isi       <= (evt && state == ISI_RUN) ? isi_cnt : isi;
            isi_cnt   <= evt ? ISI_W'(1) :
                         (state == ISI_RUN && !(&isi_cnt)) ? isi_cnt + 1'b1 : isi_cnt;
        end
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: random and directed spike trains checked against an edge-time model.
module tb_spike_rate_decoder;
    logic clk = 1'b0, rst_n, ena, spike;
    logic [7:0] rate, isi, isi2;
    logic [1:0] rate2;
    logic rate_valid, rate_sat, isi_valid, rate_valid2, rate_sat2, isi_valid2;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW_LOG2(4), .CNT_W(8), .ISI_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike),
        .rate(rate), .rate_valid(rate_valid), .rate_sat(rate_sat),
        .isi(isi), .isi_valid(isi_valid)
    );

    spike_rate_decoder #(.WINDOW_LOG2(4), .CNT_W(2), .ISI_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike),
        .rate(rate2), .rate_valid(rate_valid2), .rate_sat(rate_sat2),
        .isi(isi2), .isi_valid(isi_valid2)
    );

    // Model: counts edges per 16 enabled cycles and remembers the last edge time.
    int m_prev, m_n, m_edges, m_t, m_last;
    int e_rate, e_sat, e_rate2, e_sat2, e_rv, e_isi, e_iv;
    always @(posedge clk or negedge rst_n) begin : model
        int ev, ed;
        if (!rst_n) begin
            m_prev <= 0; m_n <= 0; m_edges <= 0; m_t <= 0; m_last <= -1;
            e_rate <= 0; e_sat <= 0; e_rate2 <= 0; e_sat2 <= 0; e_rv <= 0; e_isi <= 0; e_iv <= 0;
        end else begin
            ev = (spike && m_prev == 0) ? 1 : 0;
            m_prev <= int'(spike);
            e_rv <= 0;
            e_iv <= 0;
            if (!ena) begin
                m_n <= 0; m_edges <= 0; m_last <= -1;
            end else begin
                ed = m_edges + ev;
                if (m_n % 16 == 15) begin
                    e_rate <= ed > 255 ? 255 : ed;
                    e_sat <= ed > 255 ? 1 : 0;
                    e_rate2 <= ed > 3 ? 3 : ed;
                    e_sat2 <= ed > 3 ? 1 : 0;
                    e_rv <= 1;
                    m_edges <= 0;
                end else m_edges <= ed;
                m_n <= m_n + 1;
                if (ev == 1) begin
                    if (m_last >= 0) begin
                        e_isi <= (m_t - m_last) > 255 ? 255 : m_t - m_last;
                        e_iv <= 1;
                    end
                    m_last <= m_t;
                end
                m_t <= m_t + 1;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cmp();
        check("rate", int'(rate), e_rate);
        check("rate_valid", int'(rate_valid), e_rv);
        check("rate_sat", int'(rate_sat), e_sat);
        check("isi", int'(isi), e_isi);
        check("isi_valid", int'(isi_valid), e_iv);
        check("rate2", int'(rate2), e_rate2);
        check("rate_valid2", int'(rate_valid2), e_rv);
        check("rate_sat2", int'(rate_sat2), e_sat2);
        check("isi2", int'(isi2), e_isi);
        check("isi_valid2", int'(isi_valid2), e_iv);
    endtask

    task automatic step(input logic s, input logic e);
        spike = s;
        ena = e;
        @(negedge clk);
        cmp();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; spike = 1'b0;
        repeat (3) step(0, 0);
        check("reset_rate", int'(rate), 0);
        check("reset_isi", int'(isi), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 48; i++) step(i % 4 == 0, 1);
        check("periodic_rv", int'(rate_valid), 1);
        check("periodic_rate", int'(rate), 4);
        check("periodic_isi", int'(isi), 4);
        step(0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 1);
            if (i == 15) check("held_rate_first", int'(rate), 1);
            if (i == 31) check("held_rate_later", int'(rate), 0);
        end
        step(0, 0);
        for (int i = 0; i < 32; i++) begin
            step(i == 15, 1);
            if (i == 15) check("term_edge_rate", int'(rate), 1);
            if (i == 31) check("term_next_rate", int'(rate), 0);
        end
        step(0, 0);
        for (int i = 0; i < 18; i++) step(i == 10 || i == 17, 1);
        check("isi_7", int'(isi), 7);
        check("isi_7_valid", int'(isi_valid), 1);
        repeat (299) step(0, 1);
        step(1, 1);
        check("isi_sat", int'(isi), 255);
        step(0, 0);
        for (int i = 0; i < 32; i++) begin
            step(i < 16 ? (i % 2 == 0) : (i == 16 || i == 20), 1);
            if (i == 15) begin
                check("sat_rate2", int'(rate2), 3);
                check("sat_flag2", int'(rate_sat2), 1);
                check("sat_rate8", int'(rate), 8);
            end
            if (i == 31) begin
                check("unsat_rate2", int'(rate2), 2);
                check("unsat_flag2", int'(rate_sat2), 0);
            end
        end
        step(0, 0);
        for (int i = 0; i < 9; i++) step(i == 2, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_rate", int'(rate), 0);
        check("async_rst_isi", int'(isi), 0);
        check("async_rst_rate2", int'(rate2), 0);
        @(negedge clk);
        cmp();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(0, 1);
            if (i == 14) check("post_rst_rv_early", int'(rate_valid), 0);
            if (i == 15) check("post_rst_rv", int'(rate_valid), 1);
        end
        for (int i = 0; i < 4; i++) step(i == 0 || i == 3, 1);
        check("pre_drop_isi", int'(isi), 3);
        repeat (5) step(0, 0);
        check("drop_hold_isi", int'(isi), 3);
        for (int i = 0; i < 7; i++) begin
            step(i == 2 || i == 6, 1);
            if (i == 2) check("reena_first_iv", int'(isi_valid), 0);
            if (i == 6) check("reena_isi", int'(isi), 4);
        end
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) repeat (270) step(0, 1);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 99) != 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
